// File: rtl/fetch_unit.sv
// IF stage: PC register, instruction-memory request/ack master and IF/ID pipeline register.
// One returned word is parked in a buffer while ID is held, so a stall never causes a refetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        stall_IF_ID,
  input  logic        flush_IF_ID,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID,
  output logic [1:0]  o_dbg_state,
  output logic        o_dbg_buf_valid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  // Handshake: imem_req stays high with imem_addr stable until the cycle imem_ack=1;
  // the word is consumed in that same cycle, and ack in the first request cycle is legal.

  state_t      r_state;
  logic [31:0] r_pc_f;
  logic [31:0] r_pc_id;
  logic [31:0] r_instr_id;
  logic        r_valid_id;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_instr;
  logic        r_buf_valid;
  logic [31:0] r_tgt;

  logic        w_hold;
  logic [31:0] w_target;
  logic [31:0] w_pc_next;

  assign w_hold    = stall_IF_ID | ~PCWrite;
  assign w_target  = branch_target & ~32'h0000_0003;
  assign w_pc_next = r_pc_f + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc_f      <= RESET_PC;
      r_pc_id     <= 32'd0;
      r_instr_id  <= NOP_INSTR;
      r_valid_id  <= 1'b0;
      r_buf_pc    <= 32'd0;
      r_buf_instr <= NOP_INSTR;
      r_buf_valid <= 1'b0;
      r_tgt       <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          if (branch_taken) r_pc_f <= w_target;
          if (branch_taken || flush_IF_ID) begin
            r_valid_id <= 1'b0;
            r_instr_id <= NOP_INSTR;
          end
        end

        S_FETCH: begin
          if (branch_taken) begin
            r_valid_id <= 1'b0;
            r_instr_id <= NOP_INSTR;
            if (imem_ack) begin
              r_pc_f <= w_target;
            end else begin
              // Request in flight: finish it at the old address, then redirect.
              r_tgt   <= w_target;
              r_state <= S_DISCARD;
            end
          end else if (imem_ack && (flush_IF_ID || w_hold)) begin
            r_buf_pc    <= r_pc_f;
            r_buf_instr <= imem_rdata;
            r_buf_valid <= 1'b1;
            r_pc_f      <= w_pc_next;
            r_state     <= S_HOLD;
            if (flush_IF_ID) begin
              r_valid_id <= 1'b0;
              r_instr_id <= NOP_INSTR;
            end
          end else if (imem_ack) begin
            r_pc_id    <= r_pc_f;
            r_instr_id <= imem_rdata;
            r_valid_id <= 1'b1;
            r_pc_f     <= w_pc_next;
          end else if (flush_IF_ID || !w_hold) begin
            r_valid_id <= 1'b0;
            r_instr_id <= NOP_INSTR;
          end
        end

        S_DISCARD: begin
          if (branch_taken) r_tgt <= w_target;
          if (imem_ack) begin
            r_pc_f  <= branch_taken ? w_target : r_tgt;
            r_state <= S_FETCH;
          end
          if (branch_taken || flush_IF_ID || !w_hold) begin
            r_valid_id <= 1'b0;
            r_instr_id <= NOP_INSTR;
          end
        end

        S_HOLD: begin
          if (branch_taken) begin
            r_buf_valid <= 1'b0;
            r_pc_f      <= w_target;
            r_valid_id  <= 1'b0;
            r_instr_id  <= NOP_INSTR;
            r_state     <= S_FETCH;
          end else if (flush_IF_ID) begin
            r_valid_id <= 1'b0;
            r_instr_id <= NOP_INSTR;
          end else if (!w_hold) begin
            r_pc_id     <= r_buf_pc;
            r_instr_id  <= r_buf_instr;
            r_valid_id  <= 1'b1;
            r_buf_valid <= 1'b0;
            r_state     <= S_FETCH;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req        = (r_state == S_FETCH) || (r_state == S_DISCARD);
  assign imem_addr       = r_pc_f;
  assign pc_ID           = r_pc_id;
  assign instr_ID        = r_instr_id;
  assign valid_ID        = r_valid_id;
  assign o_dbg_state     = r_state;
  assign o_dbg_buf_valid = r_buf_valid;

endmodule
